// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I control decode carried through STAGES registered stages,
// with load-use hazard detection, branch/jump redirect, global memory stall and event counters.
module pipelined_control_unit #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic             useBr,
  input  logic             mem_stall,
  output logic             in_ready,
  output logic             ex_valid,
  output logic             ex_rs1_en,
  output logic             ex_rs2_en,
  output logic             ex_brOrJmp,
  output logic             ex_use_jalr,
  output logic             ex_func1,
  output logic             ex_illegal,
  output logic [2:0]       ex_func3,
  output logic             mem_valid,
  output logic             mem_write,
  output logic [2:0]       mem_funcMem,
  output logic             wb_valid,
  output logic             wb_regWrite,
  output logic [1:0]       wb_wbSel,
  output logic [4:0]       wb_rd,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  typedef struct packed {
    logic       valid;
    logic       rs1_en;
    logic       rs2_en;
    logic       br_or_jmp;
    logic       use_jalr;
    logic       func1;
    logic       illegal;
    logic [2:0] func3;
    logic       mem_write;
    logic [2:0] func_mem;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    logic       is_load;
    logic       is_branch;
    logic       is_jump;
  } ctrl_t;
  ctrl_t dec;
  ctrl_t stg [STAGES];
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  logic rs2_haz, hazard;
  logic unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign unused_bits = ^{instr[31], instr[29:25]};
  always_comb begin
    dec = '0;
    rs2_haz = 1'b0;
    case (op)
      OP_LUI:    begin dec.wb_sel = 2'b11; dec.reg_write = 1'b1; end
      OP_AUIPC:  begin dec.wb_sel = 2'b01; dec.reg_write = 1'b1; end
      OP_JAL:    begin dec.br_or_jmp = 1'b1; dec.is_jump = 1'b1; dec.reg_write = 1'b1; end
      OP_JALR:   begin dec.rs1_en = 1'b1; dec.use_jalr = 1'b1; dec.is_jump = 1'b1; dec.reg_write = 1'b1; end
      OP_BRANCH: begin dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.func3 = f3; dec.is_branch = 1'b1; rs2_haz = 1'b1; end
      OP_STORE:  begin dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.mem_write = 1'b1; dec.func_mem = f3; rs2_haz = 1'b1; end
      OP_LOAD:   begin dec.rs1_en = 1'b1; dec.wb_sel = 2'b10; dec.reg_write = 1'b1; dec.func_mem = f3; dec.is_load = 1'b1; end
      OP_R:      begin dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.func3 = f3; dec.func1 = instr[30]; dec.wb_sel = 2'b01; dec.reg_write = 1'b1; rs2_haz = 1'b1; end
      OP_I:      begin dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.func3 = f3; dec.func1 = (f3 == 3'b101) & instr[30]; dec.wb_sel = 2'b01; dec.reg_write = 1'b1; end
      default:   dec.illegal = 1'b1;
    endcase
    dec.rd = dec.illegal ? 5'd0 : instr[11:7];
    dec.valid = 1'b1;
  end
  assign hazard = stg[0].valid & stg[0].is_load & |stg[0].rd &
                  ((dec.rs1_en & rs1 == stg[0].rd) | (rs2_haz & rs2 == stg[0].rd));
  assign redirect = stg[0].valid & !mem_stall & (stg[0].is_jump | (stg[0].is_branch & useBr));
  assign in_ready = !mem_stall & !hazard & !redirect;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!mem_stall) begin
      stg[0] <= (in_valid & in_ready) ? dec : '0;
      for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
      stall_count <= stall_count + CNT_W'(in_valid & hazard & ~&stall_count);
      flush_count <= flush_count + CNT_W'(redirect & ~&flush_count);
    end
  end
  assign ex_valid    = stg[0].valid;
  assign ex_rs1_en   = stg[0].rs1_en;
  assign ex_rs2_en   = stg[0].rs2_en;
  assign ex_brOrJmp  = stg[0].br_or_jmp;
  assign ex_use_jalr = stg[0].use_jalr;
  assign ex_func1    = stg[0].func1;
  assign ex_illegal  = stg[0].illegal;
  assign ex_func3    = stg[0].func3;
  assign mem_valid   = stg[1].valid;
  assign mem_write   = stg[1].mem_write;
  assign mem_funcMem = stg[1].func_mem;
  assign wb_valid    = stg[STAGES-1].valid;
  assign wb_regWrite = stg[STAGES-1].reg_write;
  assign wb_wbSel    = stg[STAGES-1].wb_sel;
  assign wb_rd       = stg[STAGES-1].rd;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed plus random stimulus against an instruction-level model with per-stage scoreboards.
module tb_pipelined_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, useBr = 1'b0, mem_stall = 1'b0;
  logic [31:0] instr = 32'h0;
  logic in_ready, ex_valid, ex_rs1_en, ex_rs2_en, ex_brOrJmp, ex_use_jalr, ex_func1, ex_illegal;
  logic [2:0] ex_func3, mem_funcMem;
  logic mem_valid, mem_write, wb_valid, wb_regWrite, redirect;
  logic [1:0] wb_wbSel;
  logic [4:0] wb_rd;
  logic [15:0] stall_count, flush_count;
  logic d2_in_ready, d2_ex_valid, d2_ex_rs1_en, d2_ex_rs2_en, d2_ex_brOrJmp, d2_ex_use_jalr, d2_ex_func1, d2_ex_illegal;
  logic [2:0] d2_ex_func3, d2_mem_funcMem;
  logic d2_mem_valid, d2_mem_write, d2_wb_valid, d2_wb_regWrite, d2_redirect;
  logic [1:0] d2_wb_wbSel;
  logic [4:0] d2_wb_rd;
  logic [1:0] d2_stall_count, d2_flush_count;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .useBr(useBr), .mem_stall(mem_stall),
    .in_ready(in_ready), .ex_valid(ex_valid), .ex_rs1_en(ex_rs1_en), .ex_rs2_en(ex_rs2_en),
    .ex_brOrJmp(ex_brOrJmp), .ex_use_jalr(ex_use_jalr), .ex_func1(ex_func1), .ex_illegal(ex_illegal),
    .ex_func3(ex_func3), .mem_valid(mem_valid), .mem_write(mem_write), .mem_funcMem(mem_funcMem),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_wbSel(wb_wbSel), .wb_rd(wb_rd),
    .redirect(redirect), .stall_count(stall_count), .flush_count(flush_count));

  pipelined_control_unit #(.STAGES(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .useBr(useBr), .mem_stall(mem_stall),
    .in_ready(d2_in_ready), .ex_valid(d2_ex_valid), .ex_rs1_en(d2_ex_rs1_en), .ex_rs2_en(d2_ex_rs2_en),
    .ex_brOrJmp(d2_ex_brOrJmp), .ex_use_jalr(d2_ex_use_jalr), .ex_func1(d2_ex_func1), .ex_illegal(d2_ex_illegal),
    .ex_func3(d2_ex_func3), .mem_valid(d2_mem_valid), .mem_write(d2_mem_write), .mem_funcMem(d2_mem_funcMem),
    .wb_valid(d2_wb_valid), .wb_regWrite(d2_wb_regWrite), .wb_wbSel(d2_wb_wbSel), .wb_rd(d2_wb_rd),
    .redirect(d2_redirect), .stall_count(d2_stall_count), .flush_count(d2_flush_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic rs1, rs2, brj, jalr, f1, ill;
    logic [2:0] f3;
    logic mw;
    logic [2:0] fm;
    logic rw;
    logic [1:0] ws;
    logic [4:0] rd;
  } exp_t;

  exp_t ex_q[$], mem_q[$], wb_q[$];
  int errs = 0, checks = 0;
  int scnt = 0, fcnt = 0;
  logic m_ex_v = 1'b0;
  logic [31:0] m_ex_i = 32'h0;
  logic adv = 1'b0, held = 1'b0, exp_acc = 1'b0;
  logic [23:0] outs, snap = '0;
  assign outs = {ex_valid, ex_rs1_en, ex_rs2_en, ex_brOrJmp, ex_use_jalr, ex_func1, ex_illegal, ex_func3,
                 mem_valid, mem_write, mem_funcMem, wb_valid, wb_regWrite, wb_wbSel, wb_rd};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode table expressed from the instruction set's point of view.
  function automatic exp_t dec(input logic [31:0] i);
    exp_t e;
    logic [2:0] f;
    e = '0;
    f = i[14:12];
    case (i[6:0])
      7'h37: begin e.ws = 2'd3; e.rw = 1; e.rd = i[11:7]; end
      7'h17: begin e.ws = 2'd1; e.rw = 1; e.rd = i[11:7]; end
      7'h6F: begin e.brj = 1; e.rw = 1; e.rd = i[11:7]; end
      7'h67: begin e.rs1 = 1; e.jalr = 1; e.rw = 1; e.rd = i[11:7]; end
      7'h63: begin e.rs1 = 1; e.rs2 = 1; e.f3 = f; end
      7'h23: begin e.rs1 = 1; e.rs2 = 1; e.mw = 1; e.fm = f; end
      7'h03: begin e.rs1 = 1; e.ws = 2'd2; e.rw = 1; e.fm = f; e.rd = i[11:7]; end
      7'h33: begin e.rs1 = 1; e.rs2 = 1; e.f3 = f; e.f1 = i[30]; e.ws = 2'd1; e.rw = 1; e.rd = i[11:7]; end
      7'h13: begin e.rs1 = 1; e.rs2 = 1; e.f3 = f; e.f1 = (f == 3'd5) ? i[30] : 1'b0; e.ws = 2'd1; e.rw = 1; e.rd = i[11:7]; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic load_use(input logic [31:0] ld, input logic [31:0] d);
    logic [4:0] r;
    r = ld[11:7];
    if (ld[6:0] != 7'h03 || r == 5'd0) return 1'b0;
    return (dec(d).rs1 && d[19:15] == r) || ((d[6:0] inside {7'h33, 7'h63, 7'h23}) && d[24:20] == r);
  endfunction

  // Reference model: predicts handshake/redirect and pushes the expected bundle for the coming edge.
  always @(negedge clk) begin
    logic hz, rdr, rdy;
    if (rst) begin
      adv = 1'b0;
      held = 1'b0;
      exp_acc = 1'b0;
    end else begin
      hz = m_ex_v && load_use(m_ex_i, instr);
      rdr = m_ex_v && !mem_stall && (m_ex_i[6:0] inside {7'h6F, 7'h67} || (m_ex_i[6:0] == 7'h63 && useBr));
      rdy = !mem_stall && !hz && !rdr;
      chk("in_ready", in_ready, rdy);
      chk("redirect", redirect, rdr);
      chk("d2_in_ready", d2_in_ready, rdy);
      adv = !mem_stall;
      held = mem_stall;
      if (!mem_stall) begin
        if (in_valid && hz) scnt++;
        if (rdr) fcnt++;
        exp_acc = in_valid && rdy;
        if (exp_acc) begin
          ex_q.push_back(dec(instr));
          mem_q.push_back(dec(instr));
          wb_q.push_back(dec(instr));
        end
        m_ex_v = exp_acc;
        m_ex_i = instr;
      end
    end
  end

  // Monitor: pops a stage's scoreboard whenever that stage presents a fresh valid bundle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      chk("stall_count", stall_count, (scnt > 65535) ? 65535 : scnt);
      chk("flush_count", flush_count, (fcnt > 65535) ? 65535 : fcnt);
      chk("d2_stall_count", d2_stall_count, (scnt > 3) ? 3 : scnt);
      chk("d2_flush_count", d2_flush_count, (fcnt > 3) ? 3 : fcnt);
      if (adv) begin
        chk("ex_valid", ex_valid, exp_acc);
        if (ex_valid && ex_q.size() > 0) begin
          e = ex_q.pop_front();
          chk("ex_ctrl", {ex_rs1_en, ex_rs2_en, ex_brOrJmp, ex_use_jalr, ex_func1, ex_illegal, ex_func3},
              {e.rs1, e.rs2, e.brj, e.jalr, e.f1, e.ill, e.f3});
        end
        if (mem_valid) begin
          if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
          else begin
            e = mem_q.pop_front();
            chk("mem_ctrl", {mem_write, mem_funcMem}, {e.mw, e.fm});
          end
        end
        if (wb_valid) begin
          if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
          else begin
            e = wb_q.pop_front();
            chk("wb_regWrite", wb_regWrite, e.rw);
            if (e.rw) chk("wb_sel_rd", {wb_wbSel, wb_rd}, {e.ws, e.rd});
          end
        end
      end
      if (held) chk("held_outputs", outs, snap);
    end
    snap = outs;
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic ub, input logic ms);
    @(posedge clk);
    #2;
    in_valid = v;
    instr = i;
    useBr = ub;
    mem_stall = ms;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    mem_stall = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
    chk("rst_counters", {stall_count, flush_count, d2_stall_count, d2_flush_count}, 36'h0);
    chk("rst_redirect", redirect, 0);
    chk("rst_in_ready", in_ready, 1);
    ex_q.delete();
    mem_q.delete();
    wb_q.delete();
    scnt = 0;
    fcnt = 0;
    m_ex_v = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03, 7'h33, 7'h13, 7'h7F};
    return {1'b0, 1'($urandom), 5'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
  endfunction

  localparam logic [31:0] ADDI = 32'h00100093, LW5 = 32'h00002283, ADD65 = 32'h00028333;
  localparam logic [31:0] LW0 = 32'h00002003, ADD600 = 32'h00000333, BEQ = 32'h00000063, JAL = 32'h000000EF;

  initial begin
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle(2);
    do_reset();
    drive(1, ADDI, 0, 0);
    idle(4);
    drive(1, LW5, 0, 0);
    drive(1, ADD65, 0, 0);
    drive(1, ADD65, 0, 0);
    idle(4);
    drive(1, LW0, 0, 0);
    drive(1, ADD600, 0, 0);
    idle(4);
    chk("load_use_stall_once", stall_count, 1);
    drive(1, BEQ, 0, 0);
    drive(1, ADDI, 1, 0);
    drive(1, ADDI, 0, 0);
    idle(3);
    drive(1, BEQ, 0, 0);
    drive(1, ADDI, 0, 0);
    idle(3);
    drive(1, JAL, 0, 0);
    repeat (3) drive(1, ADDI, 0, 1);
    drive(1, ADDI, 0, 0);
    drive(1, ADDI, 0, 0);
    idle(4);
    chk("flush_after_jal", flush_count, 2);
    drive(1, 32'h0000007F, 0, 0);
    idle(4);
    repeat (5) begin
      drive(1, LW5, 0, 0);
      drive(1, ADD65, 0, 0);
      drive(1, ADD65, 0, 0);
    end
    idle(4);
    chk("d2_stall_saturated", d2_stall_count, 3);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      drive($urandom_range(0, 3) != 0, rnd_instr(), 1'($urandom), $urandom_range(0, 7) == 0);
    end
    idle(10);
    chk("ex_q_drained", ex_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised, pipelined successor to the single-cycle RV32I control decoder. It decodes the instruction held in the decode stage into the control bundle and carries that bundle through `STAGES` registered pipeline stages (EX, MEM, then WB as the last stage). It also detects load-use hazards, generates the redirect/flush for taken branches and jumps, honours a global memory stall, and counts stall and flush events. It sits between instruction fetch/decode and the datapath, replacing per-cycle combinational control.

## Interface
Parameters:
- `STAGES`, default 3: number of registered control stages. Stage 1 is EX, stage 2 is MEM, stage `STAGES` is WB. Legal range 3..6.
- `CNT_W`, default 16: width of the saturating event counters.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `instr` in decode is valid.
- `instr`  in  32: fields are opcode `[6:0]`, rd `[11:7]`, f3 `[14:12]`, rs1 `[19:15]`, rs2 `[24:20]`, f1 `[30]`.
- `useBr`  in  1: branch comparator result for the instruction in EX.
- `mem_stall`  in  1: freezes the whole pipeline.
- `in_ready`  out  1: decode instruction is accepted at this edge.
- `ex_valid, ex_rs1_en, ex_rs2_en, ex_brOrJmp, ex_use_jalr, ex_func1, ex_illegal`  out  1 each: EX-stage control.
- `ex_func3`  out  3: EX-stage ALU function code.
- `mem_valid, mem_write`  out  1 each: MEM-stage control.
- `mem_funcMem`  out  3: MEM-stage memory function code.
- `wb_valid, wb_regWrite`  out  1 each: WB-stage control.
- `wb_wbSel`  out  2: writeback source select.
- `wb_rd`  out  5: destination register.
- `redirect`  out  1: PC redirect; younger instructions are flushed.
- `stall_count, flush_count`  out  `CNT_W` each: saturating event counters.

## Operation
Decode table (combinational, decode stage). wbSel encoding: 00 = PC+4, 01 = ALU, 10 = memory, 11 = immediate.
- LUI: wbSel 11, regWrite 1.
- AUIPC: wbSel 01, ADD, regWrite 1.
- JAL: brOrJmp 1, wbSel 00, regWrite 1.
- JALR: rs1_en 1, use_jalr 1, ADD, wbSel 00, regWrite 1.
- BRANCH: rs1_en 1, rs2_en 1, func3 = f3, regWrite 0.
- STORE: rs1_en 1, rs2_en 1, ADD, mem_write 1, funcMem = f3.
- LOAD: rs1_en 1, ADD, wbSel 10, regWrite 1, funcMem = f3.
- R-type: rs1_en 1, rs2_en 1, func3 = f3, func1 = f1, wbSel 01, regWrite 1.
- I-type: rs1_en 1, rs2_en 1, func3 = f3, func1 = f1 only when f3 = SRL/SRA (else 0), wbSel 01, regWrite 1.
- Any other opcode: illegal = 1, every other field 0.

Control fields are don't-care when the stage's valid bit is 0. Bubbles carry all zeros.

Rules:
- **Load-use hazard.** `hazard` is asserted when all of the following hold: `ex_valid` is set, EX holds a LOAD, and its rd is nonzero. In addition, one of the following must hold for the decode instruction:
  - it uses rs1 and rs1 == EX.rd; or
  - it is R-type, BRANCH or STORE and rs2 == EX.rd.
- **Redirect.** `redirect = ex_valid & !mem_stall & (JAL | JALR | (BRANCH & useBr))`.
- **Ready.** `in_ready = !mem_stall & !hazard & !redirect`.
- **Stage advance**, when `mem_stall` = 0:
  - Stage k+1 takes stage k, for every k.
  - Stage 1 loads the decoded bundle with valid = `in_valid & in_ready`; otherwise it loads a bubble.
- **Redirect priority.** Redirect overrides hazard. The decode instruction is dropped and not accepted, and upstream refetches it.
- **Memory stall.** When `mem_stall` = 1, all stages hold and no counter changes.
- **Counters.**
  - `stall_count` +1 on each cycle with `in_valid & hazard & !mem_stall`.
  - `flush_count` +1 on each cycle with `redirect`.
  - Both saturate at all-ones.
- **Reset.** All valid bits, control fields and counters clear to 0. `redirect` = 0. `in_ready` = `!mem_stall` (1 when idle).

## Timing
- Instruction accepted at edge t: EX outputs are valid after t. MEM is valid one cycle later, and WB is valid `STAGES-1` cycles after EX. Each `mem_stall` cycle adds one cycle to these latencies.
- `redirect`, `in_ready` and `hazard` are combinational from the registered EX stage plus the current inputs; there is no input-to-output registered path.
- A load-use stall costs exactly one bubble. The dependent instruction enters EX two cycles after the LOAD.
- A taken redirect costs exactly one bubble in EX. It is asserted once per jump, even if `mem_stall` delays it.
- Reset asserted mid-stream clears every stage immediately, without waiting for a clock edge.

## Test plan
- **Reset.** Apply `rst` with random state present → all valid bits 0, counters 0, `redirect` 0, `in_ready` 1.
- **Simple ALU op.** ADDI x1,x0,1 (0x00100093) accepted at t:
  - EX shows wbSel 01, func3 000, rs1_en 1 after t.
  - `wb_valid`, `wb_regWrite` = 1 and `wb_rd` = 1 appear 2 cycles later (`STAGES` = 3).
- **Load-use.**
  - LW x5 followed by ADD x6,x5,x0 → `in_ready` = 0 for 1 cycle, one bubble in EX, ADD reaches EX 2 cycles after LW, `stall_count` = 1.
  - Same sequence with LW x0 → no stall.
- **Taken branch.** BEQ in EX with `useBr` = 1 → `redirect` = 1 for 1 cycle, next EX is a bubble, `flush_count` = 1. With `useBr` = 0 → no redirect and the stream continues.
- **Memory stall over a jump.** JAL in EX, `mem_stall` = 1 for 3 cycles:
  - Outputs are frozen, `redirect` = 0, `in_ready` = 0.
  - On release, `redirect` pulses exactly once and `flush_count` = 1.
- **Illegal opcode and saturation.**
  - Opcode 0x7F → `ex_illegal` = 1, `wb_regWrite` = 0.
  - With `CNT_W` = 2, 5 load-use stalls → `stall_count` = 3.
